// File: rtl/sdr_write.sv
// Single-burst SDR SDRAM write engine: ACTIVE, then WRITE with auto-precharge,
// drives BL data words on DQ and pulses done_w once the bank has closed.
module sdr_write #(
    parameter int BL   = 4,
    parameter int TRCD = 2,
    parameter int TWR  = 2,
    parameter int TRP  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_w,
    output logic               done_w,
    input  logic [24:0]        laddr_w,
    input  logic [BL*16-1:0]   wrdata,
    input  logic [BL*2-1:0]    wrmask,
    output logic [4:0]         cmd_w,
    output logic [12:0]        addr_w,
    output logic [1:0]         ba_w,
    output logic [15:0]        dq_w,
    output logic               dq_oe,
    output logic [1:0]         dqm_w
);

    localparam logic [4:0] CMD_INIT   = 5'b0_1_111;
    localparam logic [4:0] CMD_NOP    = 5'b1_0_111;
    localparam logic [4:0] CMD_ACTIVE = 5'b1_0_011;
    localparam logic [4:0] CMD_WRITE  = 5'b1_0_100;

    // Wide enough for the whole TRCD+BL+TWR+TRP sequence.
    localparam int CW = $clog2(TRCD + BL + TWR + TRP + 1);

    localparam logic [CW-1:0] ACT_LAST  = CW'(TRCD - 1);
    localparam logic [CW-1:0] WR_LAST   = CW'(BL - 1);
    localparam logic [CW-1:0] REC_LAST  = CW'(TWR + TRP - 1);
    localparam logic [CW-1:0] DONE_PREV = CW'(TWR + TRP - 2);

    typedef enum logic [1:0] {
        IDLE,
        ACT,
        WR,
        RECOV
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BL*16-1:0]  data_q;
    logic [BL*2-1:0]   mask_q;
    logic [9:0]        col_q;
    logic              accept;
    logic              take_word;

    assign accept    = (state == IDLE) && req_w;
    // A word leaves the payload shifter on the WRITE cycle and every further data cycle.
    assign take_word = ((state == ACT) && (cnt == ACT_LAST)) ||
                       ((state == WR)  && (cnt != WR_LAST));

    // NOTE: payload registers have no reset; they are always loaded on acceptance
    // before anything reads them, so a reset would only cost routing.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= wrdata;
            mask_q <= wrmask;
            col_q  <= laddr_w[9:0];
        end else if (take_word) begin
            data_q <= data_q >> 16;
            mask_q <= mask_q >> 2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cmd_w  <= CMD_INIT;
            addr_w <= '0;
            ba_w   <= '0;
            dq_w   <= '0;
            dq_oe  <= 1'b0;
            dqm_w  <= 2'b11;
            done_w <= 1'b0;
        end else begin
            // NOTE: defaults first, then per-state overrides; all assignments here
            // are non-blocking so every output is a clean register.
            cmd_w  <= CMD_NOP;
            done_w <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_w) begin
                        state  <= ACT;
                        cnt    <= '0;
                        cmd_w  <= CMD_ACTIVE;
                        ba_w   <= laddr_w[24:23];
                        addr_w <= laddr_w[22:10];
                    end
                end
                ACT: begin
                    if (cnt == ACT_LAST) begin
                        state  <= WR;
                        cnt    <= '0;
                        cmd_w  <= CMD_WRITE;
                        addr_w <= {2'b00, 1'b1, col_q};
                        dq_w   <= data_q[15:0];
                        dqm_w  <= mask_q[1:0];
                        dq_oe  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (cnt == WR_LAST) begin
                        state <= RECOV;
                        cnt   <= '0;
                        dq_w  <= '0;
                        dqm_w <= 2'b11;
                        dq_oe <= 1'b0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        dq_w  <= data_q[15:0];
                        dqm_w <= mask_q[1:0];
                    end
                end
                RECOV: begin
                    // done_w is registered, so it is raised one cycle ahead of the last RECOV cycle.
                    done_w <= (cnt == DONE_PREV);
                    if (cnt == REC_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_write.sv
// Directed bench for sdr_write: default instance plus a TRCD=3/TWR=1/TRP=3/BL=8 instance.
module tb_sdr_write;

    localparam logic [4:0] INIT   = 5'b0_1_111;
    localparam logic [4:0] NOP    = 5'b1_0_111;
    localparam logic [4:0] ACTIVE = 5'b1_0_011;
    localparam logic [4:0] WRITE  = 5'b1_0_100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic req_a, req_b;
    logic [24:0] laddr_a, laddr_b;
    logic [63:0] wd_a;
    logic [7:0] wm_a;
    logic [127:0] wd_b;
    logic [15:0] wm_b;

    logic done_a, oe_a, done_b, oe_b;
    logic [4:0] cmd_a, cmd_b;
    logic [12:0] addr_a, addr_b;
    logic [1:0] ba_a, ba_b, dqm_a, dqm_b;
    logic [15:0] dq_a, dq_b;

    sdr_write u_def (
        .clk(clk), .rst_n(rst_n), .req_w(req_a), .done_w(done_a), .laddr_w(laddr_a),
        .wrdata(wd_a), .wrmask(wm_a), .cmd_w(cmd_a), .addr_w(addr_a), .ba_w(ba_a),
        .dq_w(dq_a), .dq_oe(oe_a), .dqm_w(dqm_a)
    );

    sdr_write #(.BL(8), .TRCD(3), .TWR(1), .TRP(3)) u_sweep (
        .clk(clk), .rst_n(rst_n), .req_w(req_b), .done_w(done_b), .laddr_w(laddr_b),
        .wrdata(wd_b), .wrmask(wm_b), .cmd_w(cmd_b), .addr_w(addr_b), .ba_w(ba_b),
        .dq_w(dq_b), .dq_oe(oe_b), .dqm_w(dqm_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  t_cmd  [64];
    logic [12:0] t_addr [64];
    logic [1:0]  t_ba   [64];
    logic [15:0] t_dq   [64];
    logic        t_oe   [64];
    logic [1:0]  t_dqm  [64];
    logic        t_done [64];

    localparam logic [24:0]  BASIC_ADDR = {2'b10, 13'h0155, 10'h004};
    localparam logic [63:0]  BASIC_DATA = 64'h4444_3333_2222_1111;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic capture(input bit sel, input int c);
        if (sel) begin
            t_cmd[c] = cmd_b; t_addr[c] = addr_b; t_ba[c] = ba_b;
            t_dq[c] = dq_b; t_oe[c] = oe_b; t_dqm[c] = dqm_b; t_done[c] = done_b;
        end else begin
            t_cmd[c] = cmd_a; t_addr[c] = addr_a; t_ba[c] = ba_a;
            t_dq[c] = dq_a; t_oe[c] = oe_a; t_dqm[c] = dqm_a; t_done[c] = done_a;
        end
    endtask

    // Caller has raised req in cycle 0; records cycles 0..ncyc-1 and returns #1 into cycle ncyc.
    task automatic run(input bit sel, input int ncyc, input bit hold_req, input bit chg1);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            capture(sel, c);
            @(posedge clk);
            #1;
            if (!hold_req) begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            if (chg1 && c == 0) begin
                laddr_a = 25'h1FF_FFFF;
                wd_a    = 64'hDEAD_BEEF_CAFE_F00D;
                wm_a    = 8'hFF;
            end
        end
    endtask

    // Expected bus behaviour relative to cycle o (the accept cycle).
    task automatic verify(input string nm, input int o, input int ncyc, input int w,
                          input int bl, input int dn, input logic [127:0] words,
                          input logic [15:0] masks, input logic [1:0] ba,
                          input logic [12:0] row, input logic [9:0] col);
        for (int r = 0; r < ncyc; r++) begin
            int c;
            bit d;
            logic [4:0] ec;
            c  = o + r;
            ec = (r == 1) ? ACTIVE : (r == w) ? WRITE : NOP;
            check($sformatf("%s c%0d cmd", nm, c), t_cmd[c], ec);
            if (r == 1 || r == w) begin
                check($sformatf("%s c%0d ba", nm, c), t_ba[c], ba);
                check($sformatf("%s c%0d addr", nm, c), t_addr[c],
                      (r == 1) ? row : {3'b001, col});
            end
            d = (r >= w) && (r < w + bl);
            check($sformatf("%s c%0d dq", nm, c), t_dq[c], d ? words[16*(r-w) +: 16] : 16'h0);
            check($sformatf("%s c%0d dq_oe", nm, c), t_oe[c], d);
            check($sformatf("%s c%0d dqm", nm, c), t_dqm[c], d ? masks[2*(r-w) +: 2] : 2'b11);
            check($sformatf("%s c%0d done", nm, c), t_done[c], r == dn);
        end
    endtask

    task automatic start_a(input logic [7:0] mask);
        @(posedge clk);
        #1;
        laddr_a = BASIC_ADDR;
        wd_a    = BASIC_DATA;
        wm_a    = mask;
        req_a   = 1'b1;
    endtask

    task automatic reset_and_check(input string nm);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({nm, " rst cmd"}, cmd_a, INIT);
        check({nm, " rst addr"}, addr_a, 13'h0);
        check({nm, " rst ba"}, ba_a, 2'b00);
        check({nm, " rst dq"}, dq_a, 16'h0);
        check({nm, " rst dq_oe"}, oe_a, 1'b0);
        check({nm, " rst dqm"}, dqm_a, 2'b11);
        check({nm, " rst done"}, done_a, 1'b0);
        check({nm, " rst cmd sweep"}, cmd_b, INIT);
        rst_n = 1'b1;
        #1;
        check({nm, " first cycle after release"}, cmd_a, INIT);
        @(posedge clk);
        #1;
        check({nm, " nop after release"}, cmd_a, NOP);
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        laddr_a = '0; laddr_b = '0;
        wd_a = '0; wm_a = '0; wd_b = '0; wm_b = '0;

        reset_and_check("init");

        // Basic write with default parameters.
        start_a(8'h00);
        run(1'b0, 13, 1'b0, 1'b0);
        verify("basic", 0, 13, 3, 4, 10, {64'h0, BASIC_DATA}, 16'h0000, 2'b10, 13'h0155, 10'h004);

        // Byte masks: dqm 11, 01, 10, 00 in cycles 3..6.
        start_a(8'b00_10_01_11);
        run(1'b0, 12, 1'b0, 1'b0);
        verify("mask", 0, 12, 3, 4, 10, {64'h0, BASIC_DATA}, 16'h00_27, 2'b10, 13'h0155, 10'h004);
        check("mask word1 dqm", t_dqm[4], 2'b01);

        // Inputs changed after acceptance must not leak into the burst.
        start_a(8'h00);
        run(1'b0, 12, 1'b0, 1'b1);
        verify("latch", 0, 12, 3, 4, 10, {64'h0, BASIC_DATA}, 16'h0000, 2'b10, 13'h0155, 10'h004);

        // Request held high: second ACTIVE at 12, second done at 21.
        start_a(8'h00);
        run(1'b0, 23, 1'b1, 1'b0);
        req_a = 1'b0;
        verify("b2b first", 0, 11, 3, 4, 10, {64'h0, BASIC_DATA}, 16'h0000, 2'b10, 13'h0155, 10'h004);
        verify("b2b second", 11, 12, 3, 4, 10, {64'h0, BASIC_DATA}, 16'h0000, 2'b10, 13'h0155, 10'h004);
        check("b2b active at 12", t_cmd[12], ACTIVE);
        check("b2b done at 21", t_done[21], 1'b1);
        repeat (12) @(posedge clk);

        // Reset asserted during cycle 4, while word 1 is on the bus.
        start_a(8'h00);
        run(1'b0, 4, 1'b0, 1'b0);
        check("midrst pre dq_oe", oe_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst cmd", cmd_a, INIT);
        check("midrst dq_oe", oe_a, 1'b0);
        check("midrst dqm", dqm_a, 2'b11);
        check("midrst dq", dq_a, 16'h0);
        check("midrst done", done_a, 1'b0);
        reset_and_check("midrst");
        start_a(8'h00);
        run(1'b0, 12, 1'b0, 1'b0);
        verify("after rst", 0, 12, 3, 4, 10, {64'h0, BASIC_DATA}, 16'h0000, 2'b10, 13'h0155, 10'h004);

        // Sweep instance: ACTIVE 1, WRITE 4, data 4..11, done 15.
        @(posedge clk);
        #1;
        laddr_b = {2'b01, 13'h1ABC, 10'h018};
        wd_b    = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
        wm_b    = 16'hA5C3;
        req_b   = 1'b1;
        run(1'b1, 17, 1'b0, 1'b0);
        verify("sweep", 0, 17, 4, 8, 15, 128'h8888_7777_6666_5555_4444_3333_2222_1111,
               16'hA5C3, 2'b01, 13'h1ABC, 10'h018);
        check("sweep last word", t_dq[11], 16'h8888);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdr_write.md
# sdr_write

Single-burst SDR SDRAM write engine. It accepts one write request carrying a 25-bit linear address, `BL` 16-bit data words and per-word byte masks. It then issues ACTIVE, and after that WRITE with auto-precharge, driving the burst onto the DQ bus. It pulses `done_w` once the bank has closed. It sits beside the burst read engine under the SDRAM controller arbiter, which muxes its command, address and DQ outputs onto the device pins.

## Interface
- `BL`, 4: burst length in words. Allowed values are 1, 2, 4 or 8, and `BL` must equal the mode-register burst length.
- `TRCD`, 2: cycles from ACTIVE to WRITE (≥1).
- `TWR`, 2: write-recovery cycles after the last data word (≥1).
- `TRP`, 2: precharge cycles before the bank counts as idle (≥1).
- `clk` in 1: system clock, also the SDRAM CK.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_w` in 1: write request, sampled only in IDLE.
- `done_w` out 1: one-cycle pulse when the write has fully completed.
- `laddr_w` in 25: linear address `{ba[1:0], row[12:0], col[9:0]}`.
- `wrdata` in BL*16: burst data. Word k is `wrdata[16k+15:16k]`, and word 0 is written first.
- `wrmask` in BL*2: byte masks. `wrmask[2k+1:2k]` is the DQM value for word k (1 = byte masked); bit 1 is the upper byte.
- `cmd_w` out 5: `{cke, cs_n, ras_n, cas_n, we_n}`.
- `addr_w` out 13: row/column multiplexed address.
- `ba_w` out 2: bank address.
- `dq_w` out 16: write data.
- `dq_oe` out 1: DQ output enable for the pad tristate.
- `dqm_w` out 2: data mask.

## Operation
- Command encodings:
  - INIT `5'b0_1_111`
  - NOP `5'b1_0_111`
  - ACTIVE `5'b1_0_011`
  - WRITE `5'b1_0_100`
- All outputs are registered.
- States and transitions:
  - IDLE → ACT on `req_w=1`.
  - ACT → WR after TRCD cycles.
  - WR → RECOV after BL data cycles.
  - RECOV → IDLE after TWR+TRP cycles; `done_w` is asserted in the final RECOV cycle.
- On acceptance (IDLE and `req_w=1`), the block latches `laddr_w`, `wrdata` and `wrmask` internally. Input changes after that edge have no effect on the current burst.
- ACTIVE: `ba_w` = `laddr[24:23]`, `addr_w` = `laddr[22:10]`.
- WRITE: `ba_w` = `laddr[24:23]`, `addr_w` = `{2'b00, 1'b1, laddr[9:0]}`. A10=1 selects auto-precharge.
- Column alignment to BL is the caller's responsibility. The block passes `col` through unmodified.
- Data phase: word k is driven on `dq_w` with `dqm_w` = its mask, and `dq_oe`=1, for BL consecutive cycles. Write latency is 0, so word 0 shares the WRITE cycle.
- Outside the data phase: `dq_w`=0, `dqm_w`=2'b11, `dq_oe`=0.
- All non-command cycles after reset carry NOP.
- A request is never queued. `req_w` while busy, including the `done_w` cycle, is ignored.
- The state counter must hold TRCD+BL+TWR+TRP without overflow.

## Timing
- C0 is the accept cycle (`req_w` high in IDLE).
- A = C0+1: ACTIVE on the bus.
- W = A+TRCD: WRITE on the bus and data word 0.
- L = W+BL−1: last data word.
- `done_w`=1 for exactly cycle L+TWR+TRP; IDLE is re-entered the next cycle.
- With defaults: A=1, W=3, L=6, `done_w` at 10. The earliest next ACTIVE is cycle 12 (req sampled in IDLE at cycle 11).
- Reset values:
  - `cmd_w`=INIT
  - `addr_w`=0, `ba_w`=0
  - `dq_w`=0, `dq_oe`=0
  - `dqm_w`=2'b11
  - `done_w`=0
  - state IDLE
- Reset mid-operation: outputs take reset values immediately and asynchronously, with no `done_w`. The burst is abandoned. The controller must re-initialise or precharge the SDRAM.
- The first cycle after reset release outputs INIT. NOP is output from the first clock edge after reset release onwards.

## Test plan
- **Basic write, defaults.** Stimulus: `laddr` = {2'b10, 13'h0155, 10'h004}, `wrdata` = 64'h4444_3333_2222_1111, `wrmask` = 0, req at cycle 0. Required response:
  - ACTIVE at cycle 1 with `ba_w`=2, `addr_w`=13'h0155.
  - WRITE at cycle 3 with `addr_w`=13'h0404.
  - `dq_w` = 1111, 2222, 3333, 4444 in cycles 3–6, `dq_oe` high only in those cycles.
  - `done_w` high in cycle 10 only.
- **Masks.** Stimulus: `wrmask` = 8'b00_10_01_11. Required response: `dqm_w` = 11, 01, 10, 00 in cycles 3–6, `dq_oe` high all four cycles, `dqm_w`=11 elsewhere.
- **Latching.** Stimulus: change `laddr_w`, `wrdata` and `wrmask` at cycle 1. Required response: bus values identical to the basic-write scenario.
- **Busy and back-to-back.** Stimulus: hold `req_w` high continuously. Required response:
  - No command other than NOP between cycles 4 and 11.
  - Second ACTIVE at cycle 12, second `done_w` at cycle 21.
- **Reset mid-burst.** Stimulus: assert `rst_n`=0 during cycle 4. Required response:
  - Immediately `cmd_w`=INIT, `dq_oe`=0, `dqm_w`=11, no `done_w`.
  - After release, a new request completes per the basic-write timing.
- **Parameter sweep.** Stimulus: TRCD=3, TWR=1, TRP=3, BL=8. Required response:
  - ACTIVE at 1, WRITE at 4.
  - Eight data cycles 4–11.
  - `done_w` at cycle 15.
